// File: rtl/serial_rx_4.sv
// serial_rx_4 -- framed serial-to-parallel receiver producing 4-bit words.
//
// Frame format: start bit (0), four data bits sent LSB first, an optional
// parity bit, and a stop bit (1). The receiver takes one sample on each
// clock edge where bit_en is high. Each received word is offered downstream
// on a valid/ready handshake. The parity and framing error flags are held
// together with their word.
//
// Parameters:
//   PARITY_EN   1: the frame carries a parity bit after the data; 0: it does not
//   PARITY_ODD  0: even parity; 1: odd parity
// Ports:
//   clk         rising-edge clock
//   clear       synchronous active-high reset
//   bit_en      bit strobe; ser_i is sampled only when this is high
//   ser_i       serial data input; the line idles at 1
//   data_ready  downstream accepts data_out this cycle
//   data_out    received word; bit 0 is the first data bit received
//   data_valid  a word is being held and has not been accepted yet
//   par_err     parity mismatch on the held word
//   frm_err     the stop bit of the held word was sampled as 0
//   overrun     sticky flag: a completed frame was dropped because a word was still held
//   busy        the receiver is in the middle of a frame
module serial_rx_4 #(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       ser_i,
    input  logic       data_ready,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       par_err,
    output logic       frm_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Expected parity bit for a data word under the selected sense.
    function automatic logic parity_calc(input logic [3:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [1:0] cnt_r;
    logic [3:0] shreg_r;
    logic       par_bit_r;
    logic       done_s;
    logic       load_s;
    logic       drop_s;

    logic [3:0] data_out_r;
    logic       data_valid_r;
    logic       par_err_r;
    logic       frm_err_r;
    logic       overrun_r;
    logic       busy_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; done_s marks the edge that samples the stop bit.
    always_comb begin
        state_next_s = state_r;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bit_en && !ser_i) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                // The counter wraps from 3 to 0 on the same edge that leaves DATA.
                if (bit_en && (cnt_r == 2'd3)) begin
                    state_next_s = PARITY_EN ? ST_PARITY : ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_en) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_en) begin
                    state_next_s = ST_IDLE;
                    done_s       = 1'b1;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                done_s       = 1'b0;
            end
        endcase
    end

    // A completed frame loads the output when the output is empty or is being
    // drained on this same edge. Otherwise the frame is dropped.
    assign load_s = done_s && (!data_valid_r || data_ready);
    assign drop_s = done_s && data_valid_r && !data_ready;

    // Bit counter, data shift register and captured parity bit.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_r     <= 2'd0;
            shreg_r   <= 4'b0000;
            par_bit_r <= 1'b0;
        end else if (bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 2'd0;
                end
                ST_DATA: begin
                    // LSB-first: after four shifts the first bit sits at bit 0.
                    shreg_r <= {ser_i, shreg_r[3:1]};
                    cnt_r   <= cnt_r + 2'd1;
                end
                ST_PARITY: begin
                    par_bit_r <= ser_i;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Output word register, handshake, error flags, sticky overrun and busy.
    always_ff @(posedge clk) begin
        if (clear) begin
            data_out_r   <= 4'b0000;
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            frm_err_r    <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            if (load_s) begin
                data_out_r   <= shreg_r;
                par_err_r    <= PARITY_EN ? (parity_calc(shreg_r, PARITY_ODD) != par_bit_r) : 1'b0;
                frm_err_r    <= ~ser_i;
                data_valid_r <= 1'b1;
            end else if (data_valid_r && data_ready) begin
                data_valid_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign par_err    = par_err_r;
    assign frm_err    = frm_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_serial_rx_4.sv
// Directed self-checking bench for serial_rx_4 (PARITY_EN=1, even parity).
// Inputs change 1 time unit after each rising edge. Outputs are checked at
// that same point, so each check sees the result of the edge just taken.
module tb_serial_rx_4;

    logic       clk;
    logic       clear;
    logic       bit_en;
    logic       ser_i;
    logic       data_ready;
    logic [3:0] data_out;
    logic       data_valid;
    logic       par_err;
    logic       frm_err;
    logic       overrun;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_rx_4 #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
        .clk        (clk),
        .clear      (clear),
        .bit_en     (bit_en),
        .ser_i      (ser_i),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .par_err    (par_err),
        .frm_err    (frm_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one strobed bit and take one clock edge.
    task automatic send_bit(input logic b, input logic rdy);
        ser_i      = b;
        bit_en     = 1'b1;
        data_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Take one edge with no strobe. Garbage on ser_i must be ignored.
    task automatic idle_cycle(input logic rdy);
        ser_i      = 1'b0;
        bit_en     = 1'b0;
        data_ready = rdy;
        @(posedge clk);
        #1;
        ser_i = 1'b1;
    endtask

    // Send a full frame. data_ready is held low until the stop bit, where it
    // takes the value rdy_stop. The line returns to idle afterwards.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic stp, input logic rdy_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(d[i], 1'b0);
        end
        send_bit(p, 1'b0);
        send_bit(stp, rdy_stop);
        bit_en     = 1'b0;
        ser_i      = 1'b1;
        data_ready = 1'b0;
    endtask

    initial begin
        clear      = 1'b1;
        bit_en     = 1'b1;
        ser_i      = 1'b0;
        data_ready = 1'b0;

        // Reset for two cycles with ser_i toggling.
        @(posedge clk); #1; ser_i = 1'b1;
        @(posedge clk); #1; ser_i = 1'b0;
        check("rst_data_out", data_out, 4'h0);
        check("rst_valid", {3'b000, data_valid}, 4'h0);
        check("rst_par_err", {3'b000, par_err}, 4'h0);
        check("rst_frm_err", {3'b000, frm_err}, 4'h0);
        check("rst_overrun", {3'b000, overrun}, 4'h0);
        check("rst_busy", {3'b000, busy}, 4'h0);
        clear  = 1'b0;
        bit_en = 1'b0;
        ser_i  = 1'b1;
        idle_cycle(1'b0);

        // Good frame, 4'b1011. The bits are sent one at a time so that busy
        // and latency can be checked along the way.
        send_bit(1'b0, 1'b0);
        check("g_busy_after_start", {3'b000, busy}, 4'h1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        idle_cycle(1'b0);               // bit_en=0 gap: nothing may advance
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);           // parity bit
        check("g_valid_before_stop", {3'b000, data_valid}, 4'h0);
        send_bit(1'b1, 1'b0);           // stop bit
        bit_en = 1'b0;
        check("g_data", data_out, 4'b1011);
        check("g_valid", {3'b000, data_valid}, 4'h1);
        check("g_par_err", {3'b000, par_err}, 4'h0);
        check("g_frm_err", {3'b000, frm_err}, 4'h0);
        check("g_busy_after_stop", {3'b000, busy}, 4'h0);
        idle_cycle(1'b0);
        check("g_hold", data_out, 4'b1011);
        idle_cycle(1'b1);               // accept the word
        check("g_drain_valid", {3'b000, data_valid}, 4'h0);

        // Same data with parity bit 0 and stop bit 0. The word is still delivered.
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        check("e_data", data_out, 4'b1011);
        check("e_valid", {3'b000, data_valid}, 4'h1);
        check("e_par_err", {3'b000, par_err}, 4'h1);
        check("e_frm_err", {3'b000, frm_err}, 4'h1);
        idle_cycle(1'b1);
        check("e_drain_valid", {3'b000, data_valid}, 4'h0);

        // Overrun: the second frame arrives while the first word is still held.
        send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
        check("o_no_overrun_yet", {3'b000, overrun}, 4'h0);
        send_frame(4'b0101, 1'b0, 1'b1, 1'b0);
        check("o_data_kept", data_out, 4'b1011);
        check("o_overrun", {3'b000, overrun}, 4'h1);
        idle_cycle(1'b1);
        check("o_drain_valid", {3'b000, data_valid}, 4'h0);
        check("o_overrun_sticky", {3'b000, overrun}, 4'h1);

        // Clear, then test a new frame arriving on the same edge as the drain.
        clear = 1'b1;
        idle_cycle(1'b0);
        clear = 1'b0;
        check("c_overrun_cleared", {3'b000, overrun}, 4'h0);
        send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
        send_frame(4'b0101, 1'b0, 1'b1, 1'b1);
        check("s_valid", {3'b000, data_valid}, 4'h1);
        check("s_data", data_out, 4'b0101);
        check("s_overrun", {3'b000, overrun}, 4'h0);

        // Clear after two data bits, then receive a clean frame.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("m_busy_mid", {3'b000, busy}, 4'h1);
        clear = 1'b1;
        send_bit(1'b0, 1'b1);           // clear overrides strobe and ready
        clear = 1'b0;
        bit_en = 1'b0;
        ser_i  = 1'b1;
        check("m_busy_cleared", {3'b000, busy}, 4'h0);
        check("m_valid_cleared", {3'b000, data_valid}, 4'h0);
        send_frame(4'b0011, 1'b0, 1'b1, 1'b0);
        check("m_data", data_out, 4'b0011);
        check("m_valid", {3'b000, data_valid}, 4'h1);
        check("m_par_err", {3'b000, par_err}, 4'h0);
        check("m_frm_err", {3'b000, frm_err}, 4'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_rx_4.md
# serial_rx_4

Serial-to-parallel receiver that turns a framed, LSB-first serial bit stream into 4-bit words with parity and framing checks. It sits directly downstream of the 4-bit shift register's serial output: its right-shift output, a_par[0], drives ser_i. Each received word is presented on a valid/ready handshake for the next stage, such as a parallel load into the 4-bit counter.

## Interface
- PARITY_EN, 1: 1 = frame carries a parity bit after the data; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity (data plus parity bit has an even number of 1s); 1 = odd parity.
- clk  input  1  rising-edge clock; the only clock.
- clear  input  1  synchronous, active-high reset; sampled on posedge clk.
- bit_en  input  1  bit strobe; ser_i is sampled only on posedge clk with bit_en=1.
- ser_i  input  1  serial data; line idles at 1.
- data_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  4  received word; bit 0 is the first data bit received.
- data_valid  output  1  data_out, par_err and frm_err hold a word not yet accepted.
- par_err  output  1  parity mismatch on the held word; 0 when PARITY_EN=0.
- frm_err  output  1  stop bit of the held word was sampled as 0.
- overrun  output  1  sticky: a completed frame was dropped because the previous word was still held.
- busy  output  1  receiver is in mid-frame (state is not IDLE).

## Operation
- Frame: start bit (0), 4 data bits (LSB first), optional parity bit, stop bit (1). One sample per bit_en strobe.
- States and transitions:
  - IDLE: go to DATA when bit_en=1 and ser_i=0; bit counter := 0.
  - DATA: on each bit_en, shift right into the internal shift register (ser_i enters at bit 3); counter += 1.
  - After the 4th data bit, go to PARITY if PARITY_EN=1, otherwise to STOP.
  - PARITY: on bit_en, store ser_i, then go to STOP.
  - STOP: on bit_en, complete the frame and go to IDLE.
- Bit counter: 2 bits; the wrap from 3 to 0 coincides with leaving DATA.
- Parity check: parity_calc = ^data ^ PARITY_ODD. par_err = (parity_calc != stored parity bit).
- Frame completion (the STOP-state edge with bit_en=1):
  - Output empty (data_valid=0), or being drained this edge (data_valid=1 and data_ready=1): load data_out, par_err and frm_err = ~ser_i; data_valid := 1.
  - data_valid=1 and data_ready=0: discard the new frame and leave held outputs unchanged; overrun := 1.
- A word carrying errors is still delivered; the error flags travel with it.
- Handshake: a transfer occurs on a posedge with data_valid=1 and data_ready=1. data_valid falls the next cycle unless a new word loads on that same edge, in which case it stays 1.
- data_out, par_err and frm_err are stable while data_valid=1 and the word has not been accepted.
- overrun clears only on clear.
- bit_en=0: state, counter and shift register hold.

## Timing
- Reset values, effective on the first posedge with clear=1: state=IDLE, data_out=4'b0000, data_valid=0, par_err=0, frm_err=0, overrun=0, busy=0.
- clear overrides all other inputs. Reset mid-frame discards the partial frame and any held word.
- Latency: data_valid=1 in the cycle after the posedge that samples the stop bit. That is 6 strobes after the start-bit strobe with PARITY_EN=1, and 5 strobes with PARITY_EN=0.
- busy goes to 1 the cycle after the start-bit sample and to 0 the cycle after the stop-bit sample.
- With continuous bit_en=1, back-to-back frames are supported: the next start bit may be sampled on the strobe after the stop bit.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset: drive clear=1 for 2 cycles with ser_i toggling -> all outputs 0 and busy=0.
- Good frame, PARITY_EN=1, even parity: ser_i sequence 0,1,1,0,1,1,1 with bit_en=1 -> data_out=4'b1011, par_err=0, frm_err=0, data_valid=1 one cycle after the stop sample.
- Same frame with parity bit=0 and stop bit=0 -> data_out=4'b1011, par_err=1, frm_err=1; word is still delivered.
- Overrun: hold data_ready=0 and receive 4'b1011 then 4'b0101 -> data_out remains 4'b1011, overrun=1. Raise data_ready for one cycle -> data_valid=0 and overrun stays 1.
- Simultaneous events: data_ready=1 on the same edge as the second frame's stop sample -> data_valid stays 1, data_out=4'b0101, overrun=0.
- Reset mid-frame: assert clear after 2 data bits -> busy=0 and data_valid=0. A following full frame 4'b0011 is received correctly.
